// File: rtl/count_sequence_checker.sv
// count_sequence_checker: locks onto an incrementing counter stream and flags
// out-of-sequence samples, keeping a saturating error count and a wrap count.
`default_nettype none

module count_sequence_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      wrap_count,
  output logic [WIDTH-1:0] expected
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SYNC   = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_LEN);

  logic [1:0]       state, state_nx;
  logic [3:0]       run, run_nx;
  logic             match;
  logic             locked_nx;
  logic             err_pulse_nx;
  logic             err_sticky_nx;
  logic [ERR_W-1:0] err_count_nx;
  logic [15:0]      wrap_count_nx;
  logic [WIDTH-1:0] expected_nx;

  assign match = (count_in == expected);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      run        <= 4'd0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      wrap_count <= 16'd0;
      expected   <= '0;
    end else begin
      state      <= state_nx;
      run        <= run_nx;
      locked     <= locked_nx;
      err_pulse  <= err_pulse_nx;
      err_sticky <= err_sticky_nx;
      err_count  <= err_count_nx;
      wrap_count <= wrap_count_nx;
      expected   <= expected_nx;
    end
  end

  always_comb begin
    state_nx = state;
    run_nx   = run;
    if (in_valid) begin
      case (state)
        S_IDLE: begin
          state_nx = S_SYNC;
          run_nx   = 4'd0;
        end
        S_SYNC: begin
          // Mismatches while syncing just restart the run, no error reported
          if (!match) begin
            run_nx = 4'd0;
          end else if (run + 4'd1 == LOCK_TARGET) begin
            state_nx = S_LOCKED;
            run_nx   = 4'd0;
          end else begin
            run_nx = run + 4'd1;
          end
        end
        S_LOCKED: begin
          if (!match) begin
            state_nx = S_SYNC;
            run_nx   = 4'd0;
          end
        end
        default: begin
          state_nx = S_IDLE;
          run_nx   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    locked_nx     = (state_nx == S_LOCKED);
    err_pulse_nx  = in_valid && (state == S_LOCKED) && !match;
    err_sticky_nx = err_sticky;
    err_count_nx  = err_count;
    wrap_count_nx = wrap_count;
    expected_nx   = expected;

    if (in_valid) begin
      expected_nx = count_in + WIDTH'(1);
      if ((state == S_LOCKED) && match && (count_in == '0)) begin
        wrap_count_nx = wrap_count + 16'd1;
      end
    end

    if (err_pulse_nx) begin
      err_sticky_nx = 1'b1;
      if (!(&err_count)) begin
        err_count_nx = err_count + ERR_W'(1);
      end
    end

    // Clear wins over a coincident mismatch; the pulse itself still fires
    if (clear_err) begin
      err_sticky_nx = 1'b0;
      err_count_nx  = '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_count_sequence_checker.sv
// Self-checking bench for count_sequence_checker: directed scenarios plus a
// randomized stream compared against a behavioural model.
`default_nettype none

module tb_count_sequence_checker;

  localparam int WIDTH    = 4;
  localparam int LOCK_LEN = 3;
  localparam int ERR_W    = 2;
  localparam int ERR_MAX  = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] count_in = '0;
  logic             clear_err = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic             err_sticky;
  logic [ERR_W-1:0] err_count;
  logic [15:0]      wrap_count;
  logic [WIDTH-1:0] expected;

  int checks = 0;
  int failures = 0;

  // Behavioural model: streak of correct increments, unbounded error tally
  int m_have, m_streak, m_locked, m_exp, m_errs, m_sticky, m_wraps, m_pulse;

  count_sequence_checker #(
    .WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .count_in(count_in),
    .clear_err(clear_err), .locked(locked), .err_pulse(err_pulse),
    .err_sticky(err_sticky), .err_count(err_count), .wrap_count(wrap_count),
    .expected(expected)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_have = 0; m_streak = 0; m_locked = 0; m_exp = 0;
    m_errs = 0; m_sticky = 0; m_wraps = 0; m_pulse = 0;
  endtask

  task automatic model_step();
    int c;
    c = int'(count_in);
    m_pulse = 0;
    if (in_valid) begin
      if (m_have == 0) begin
        m_have = 1; m_streak = 0; m_locked = 0;
      end else if (c == m_exp) begin
        if (m_locked != 0) begin
          if (c == 0) m_wraps = (m_wraps + 1) % 65536;
        end else begin
          m_streak = m_streak + 1;
          if (m_streak == LOCK_LEN) begin
            m_locked = 1; m_streak = 0;
          end
        end
      end else begin
        if (m_locked != 0) begin
          m_pulse = 1; m_errs = m_errs + 1; m_sticky = 1;
        end
        m_locked = 0; m_streak = 0;
      end
      m_exp = (c + 1) % 16;
    end
    if (clear_err) begin
      m_errs = 0; m_sticky = 0;
    end
  endtask

  task automatic step(input logic v, input logic [3:0] c, input logic clr);
    @(negedge clk);
    in_valid = v; count_in = c; clear_err = clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic feed_run(input logic [3:0] start, input int n);
    logic [3:0] v;
    v = start;
    for (int i = 0; i < n; i++) begin
      step(1'b1, v, 1'b0);
      v = v + 4'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; clear_err = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({locked, err_pulse, err_sticky, err_count, wrap_count, expected} !== '0) begin
      failures++;
      $display("FAIL reset_values: got %h expected 0",
               {locked, err_pulse, err_sticky, err_count, wrap_count, expected});
    end
  endtask

  task automatic test_count_up();
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 4'(i % 16), 1'b0);
      if (err_pulse) pulses++;
      if (i == 2) begin
        checks++;
        if (locked !== 1'b0) begin
          failures++; $display("FAIL early_lock: got %b expected 0", locked);
        end
      end
      if (i == 3) begin
        checks++;
        if (locked !== 1'b1) begin
          failures++; $display("FAIL lock_at_3: got %b expected 1", locked);
        end
      end
      if (i == 16) begin
        checks++;
        if (wrap_count !== 16'd1) begin
          failures++; $display("FAIL first_wrap: got %0d expected 1", wrap_count);
        end
      end
    end
    checks++;
    if (pulses !== 0) begin
      failures++; $display("FAIL count_up_pulses: got %0d expected 0", pulses);
    end
    checks++;
    if (expected !== 4'd2) begin
      failures++; $display("FAIL count_up_expected: got %0d expected 2", expected);
    end
  endtask

  task automatic test_error_recovery();
    do_reset();
    feed_run(4'd0, 7);
    step(1'b1, 4'd9, 1'b0);
    checks++;
    if ({err_pulse, err_count, err_sticky, locked} !== {1'b1, 2'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mismatch_response: got p=%b c=%0d s=%b l=%b expected p=1 c=1 s=1 l=0",
               err_pulse, err_count, err_sticky, locked);
    end
    step(1'b1, 4'd10, 1'b0);
    checks++;
    if (err_pulse !== 1'b0) begin
      failures++; $display("FAIL pulse_width: got %b expected 0", err_pulse);
    end
    step(1'b1, 4'd11, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      failures++; $display("FAIL relock_early: got %b expected 0", locked);
    end
    step(1'b1, 4'd12, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      failures++; $display("FAIL relock_at_12: got %b expected 1", locked);
    end
  endtask

  task automatic test_valid_gap();
    do_reset();
    feed_run(4'd3, 4);
    step(1'b1, 4'd7, 1'b0);
    step(1'b0, 4'd7, 1'b0);
    checks++;
    if ({locked, err_pulse, expected} !== {1'b1, 1'b0, 4'd8}) begin
      failures++;
      $display("FAIL gap_hold: got l=%b p=%b e=%0d expected l=1 p=0 e=8", locked, err_pulse, expected);
    end
    step(1'b0, 4'd7, 1'b0);
    step(1'b1, 4'd8, 1'b0);
    checks++;
    if ({locked, err_pulse, err_count, expected} !== {1'b1, 1'b0, 2'd0, 4'd9}) begin
      failures++;
      $display("FAIL gap_resume: got l=%b p=%b c=%0d e=%0d expected l=1 p=0 c=0 e=9",
               locked, err_pulse, err_count, expected);
    end
  endtask

  task automatic test_err_saturate_clear();
    logic [3:0] cur;
    logic [1:0] want [4];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3;
    do_reset();
    feed_run(4'd0, 4);
    cur = 4'd4;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, cur + 4'd5, 1'b0);
      checks++;
      if ({err_pulse, err_count} !== {1'b1, want[k]}) begin
        failures++;
        $display("FAIL saturate_%0d: got p=%b c=%0d expected p=1 c=%0d", k, err_pulse, err_count, want[k]);
      end
      cur = cur + 4'd6;
      feed_run(cur, 3);
      cur = cur + 4'd3;
    end
    checks++;
    if ({err_sticky, locked} !== 2'b11) begin
      failures++; $display("FAIL sticky_locked: got s=%b l=%b expected s=1 l=1", err_sticky, locked);
    end
    step(1'b0, cur, 1'b1);
    checks++;
    if ({err_count, err_sticky, locked} !== {2'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL clear_err: got c=%0d s=%b l=%b expected c=0 s=0 l=1", err_count, err_sticky, locked);
    end
  endtask

  task automatic test_async_reset();
    int pulses;
    pulses = 0;
    do_reset();
    feed_run(4'd0, 17);
    step(1'b1, 4'd5, 1'b0);
    feed_run(4'd6, 3);
    feed_run(4'd9, 8);
    step(1'b1, 4'd5, 1'b0);
    feed_run(4'd6, 3);
    feed_run(4'd9, 8);
    feed_run(4'd1, 16);
    feed_run(4'd1, 16);
    checks++;
    if ({locked, err_count, wrap_count} !== {1'b1, 2'd2, 16'd5}) begin
      failures++;
      $display("FAIL pre_reset_state: got l=%b c=%0d w=%0d expected l=1 c=2 w=5", locked, err_count, wrap_count);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({locked, err_pulse, err_sticky, err_count, wrap_count, expected} !== '0) begin
      failures++;
      $display("FAIL async_reset: got %h expected 0",
               {locked, err_pulse, err_sticky, err_count, wrap_count, expected});
    end
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'(11 + i), 1'b0);
      if (err_pulse) pulses++;
      if (i == 2) begin
        checks++;
        if (locked !== 1'b0) begin
          failures++; $display("FAIL post_reset_early_lock: got %b expected 0", locked);
        end
      end
    end
    checks++;
    if ({locked, pulses} !== {1'b1, 32'd0}) begin
      failures++; $display("FAIL post_reset_lock: got l=%b pulses=%0d expected l=1 pulses=0", locked, pulses);
    end
  endtask

  task automatic test_sync_resync();
    int pulses;
    logic [3:0] seq [6];
    seq[0] = 4'd3; seq[1] = 4'd4; seq[2] = 4'd7; seq[3] = 4'd8; seq[4] = 4'd9; seq[5] = 4'd10;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, seq[i], 1'b0);
      if (err_pulse) pulses++;
      if (i == 4) begin
        checks++;
        if (locked !== 1'b0) begin
          failures++; $display("FAIL resync_early: got %b expected 0", locked);
        end
      end
    end
    checks++;
    if ({locked, pulses, err_count} !== {1'b1, 32'd0, 2'd0}) begin
      failures++;
      $display("FAIL resync_lock: got l=%b pulses=%0d c=%0d expected l=1 pulses=0 c=0", locked, pulses, err_count);
    end
  endtask

  task automatic test_random();
    logic [3:0]  cur, c;
    logic        v, clr;
    int          r, bad;
    logic [24:0] got, want;
    bad = 0;
    do_reset();
    cur = 4'($urandom);
    for (int n = 0; n < 1500; n++) begin
      r   = int'($urandom_range(0, 99));
      v   = (r < 80);
      c   = (r < 6) ? 4'($urandom) : cur;
      clr = ($urandom_range(0, 59) == 0);
      step(v, c, clr);
      if (v) cur = c + 4'd1;
      got  = {locked, err_pulse, err_sticky, err_count, wrap_count, expected};
      want = {m_locked[0], m_pulse[0], m_sticky[0],
              2'((m_errs > ERR_MAX) ? ERR_MAX : m_errs), 16'(m_wraps), 4'(m_exp)};
      checks++;
      if (got !== want) begin
        failures++;
        if (bad < 10)
          $display("FAIL random_cycle_%0d: got %h expected %h", n, got, want);
        bad++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count_up();
    test_error_recovery();
    test_valid_gap();
    test_err_saturate_clear();
    test_async_reset();
    test_sync_resync();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
